// File: rtl/bf16_accum_seq.sv
// Streaming BF16 reduction sequencer around an external LAT-stage BF16 adder.
// Interleaves NLANE partial sums during accumulation, then folds the lanes into one scalar.
module bf16_accum_seq #(
  parameter int LAT   = 4,
  parameter int NLANE = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_sub,
  output logic             add_valid,
  input  logic [15:0]      add_result,
  input  logic             add_valid_out,
  output logic [15:0]      sum_out,
  output logic             sum_valid,
  output logic             busy
);

  localparam int LW = (NLANE > 1) ? $clog2(NLANE) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, MERGE, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LW-1:0]    lp;
  logic [15:0]      partial [NLANE];
  logic [NLANE-1:0] lane_valid;
  logic [NLANE-1:0] inflight;
  logic [LAT-1:0]   tag_v;
  logic [LW-1:0]    tag_lane [LAT];

  logic          wb;
  logic [LW-1:0] wb_lane;
  logic          lp_bypass;
  logic          accept;
  logic          accum_issue;
  logic          merge_issue;
  logic [LW-1:0] lo;
  logic [LW-1:0] nx;
  logic          found_lo;
  logic          multi;
  logic [LW-1:0] issue_lane;
  logic [LW-1:0] lp_next;

  assign add_sub = 1'b0;

  // A result is only ours if a tag reaches the tail of the shadow pipeline with it.
  assign wb        = add_valid_out && tag_v[LAT-1];
  assign wb_lane   = tag_lane[LAT-1];
  assign lp_bypass = wb && (wb_lane == lp);
  assign lp_next   = (lp == LW'(NLANE - 1)) ? '0 : lp + LW'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    lo       = '0;
    nx       = '0;
    found_lo = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < NLANE; i++) begin
      if (lane_valid[i]) begin
        if (!found_lo) begin
          lo       = LW'(i);
          found_lo = 1'b1;
        end else if (!multi) begin
          nx    = LW'(i);
          multi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready    = (state == ACCUM) && (cnt != len_q) && (!inflight[lp] || lp_bypass);
    accept      = in_ready && in_valid;
    accum_issue = accept && lane_valid[lp];
    merge_issue = (state == MERGE) && (inflight == '0) && multi;
    add_valid   = accum_issue || merge_issue;
    issue_lane  = (state == MERGE) ? lo : lp;
    add_a       = lp_bypass ? add_result : partial[lp];
    add_b       = in_data;
    if (state == MERGE) begin
      add_a = partial[lo];
      add_b = partial[nx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      lp         <= '0;
      lane_valid <= '0;
      inflight   <= '0;
      tag_v      <= '0;
      sum_out    <= 16'h0000;
      sum_valid  <= 1'b0;
      busy       <= 1'b0;
      // NOTE: the small partial/tag arrays are flops, not RAM, so clearing them on reset is cheap and keeps state deterministic.
      for (int i = 0; i < NLANE; i++) partial[i] <= 16'h0000;
      for (int i = 0; i < LAT; i++) tag_lane[i] <= '0;
    end else begin
      tag_v       <= {tag_v[LAT-2:0], add_valid};
      tag_lane[0] <= issue_lane;
      for (int i = 1; i < LAT; i++) tag_lane[i] <= tag_lane[i-1];

      if (wb) begin
        partial[wb_lane]  <= add_result;
        inflight[wb_lane] <= 1'b0;
      end

      // Later assignments win, so a bypassed lane stays in flight with its new op.
      if (accept) begin
        if (!lane_valid[lp]) begin
          partial[lp]    <= in_data;
          lane_valid[lp] <= 1'b1;
        end else begin
          inflight[lp] <= 1'b1;
        end
        lp  <= lp_next;
        cnt <= cnt + LEN_W'(1);
      end

      if (merge_issue) begin
        inflight[lo]   <= 1'b1;
        lane_valid[nx] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= len;
            cnt        <= '0;
            lp         <= '0;
            lane_valid <= '0;
            busy       <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              sum_out   <= 16'h0000;
              sum_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept && (cnt == len_q - LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) state <= MERGE;
        end
        MERGE: begin
          if (!multi && (inflight == '0)) begin
            state     <= DONE;
            sum_out   <= partial[lo];
            sum_valid <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
